// File: rtl/spi_ram_burst.sv
// Parametrised single-port RAM that an SPI slave drives with 2-bit command words.
// It supports burst auto-increment addressing, a 1- or 2-stage read pipeline and a command-error pulse.
module spi_ram_burst #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter bit          AUTO_INC     = 1'b1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  cmd_err
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("spi_ram_burst: READ_LATENCY must be 1 or 2");
  end
  if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
    $error("spi_ram_burst: ADDR_WIDTH must not exceed DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  // Handshake: there is no backpressure. A word is consumed on every edge where
  // rx_valid=1, and tx_valid is a single-cycle pulse that nobody can stall.
  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic [ADDR_WIDTH-1:0] addr;

  assign cmd     = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload = din[DATA_WIDTH-1:0];
  assign addr    = payload[ADDR_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_armed;
  logic                  rd_launch;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rd_launch = rx_valid && (cmd == CMD_RD_DATA) && rd_armed;
  assign rd_word   = mem[rd_addr];

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rx_valid && (cmd == CMD_WR_DATA)) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_armed <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= rx_valid && (cmd == CMD_RD_DATA) && !rd_armed;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= addr;
          CMD_WR_DATA: if (AUTO_INC) wr_addr <= wr_addr + ADDR_WIDTH'(1);
          CMD_RD_ADDR: begin
            rd_addr  <= addr;
            rd_armed <= 1'b1;
          end
          CMD_RD_DATA: if (rd_armed && AUTO_INC) rd_addr <= rd_addr + ADDR_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

  // The first pipe stage is loaded only on a launch, so the data it holds stays valid between reads.
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_launch;
      if (rd_launch) s1_data <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign tx_valid = s2_valid;
    assign dout     = s2_data;
  end else begin : g_lat1
    assign tx_valid = s1_valid;
    assign dout     = s1_data;
  end

endmodule
